// File: rtl/eval_pkg.sv
// Constants and FSM state types shared by the evaluate-sequencer blocks.
package eval_pkg;

   localparam logic [31:0] FP_ONE     = 32'h3F80_0000;
   localparam logic [31:0] FP_NEG_ONE = 32'hBF80_0000;
   localparam logic [31:0] FP_ZERO    = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_CREDIT,
      DRAIN,
      RESPOND
   } seq_state_e;

   typedef enum logic {
      ACC_IDLE,
      ACC_WAIT
   } acc_state_e;

endpackage

// File: rtl/eval_res_fifo.sv
// Synchronous show-ahead result buffer; head visible combinationally, one-cycle push-to-pop.
// No internal flow control: the owner guarantees no push when full and no pop when empty.
module eval_res_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [PW:0]      cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = cnt_q;
   assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/eval_sequencer.sv
// Custom-instruction front end: issues elements into a fixed-latency datapath and sums its outputs.
// Element done one cycle after start when credit exists; FINISH responds once everything has drained.
module eval_sequencer
   import eval_pkg::*;
#(
   parameter int PIPE_LAT   = 34,
   parameter int ADD_LAT    = 3,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        clk_en,
   input  logic        start,
   input  logic [31:0] dataa,
   input  logic [31:0] datab,
   output logic        done,
   output logic [31:0] result,
   output logic        pipe_valid,
   output logic [31:0] pipe_x,
   input  logic [31:0] pipe_q,
   output logic [31:0] add_a,
   output logic [31:0] add_b,
   input  logic [31:0] add_q
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int AW = $clog2(ADD_LAT + 1);
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

   seq_state_e state_q, state_d;
   acc_state_e acc_q, acc_d;

   logic                done_q, pipe_valid_q, pend_first_q;
   logic [31:0]         result_q, pipe_x_q, pend_dat_q, sum_q, add_a_q, add_b_q;
   logic [PIPE_LAT-1:0] vld_sr_q;
   logic [CW-1:0]       inflight_q, fifo_cnt;
   logic [AW-1:0]       acc_cnt_q;
   logic [31:0]         fifo_rdata;
   logic                fifo_empty;

   logic accept, is_first, is_finish, credit, clear_ok, drained, go_idle, go_wait;
   logic arrive, pop, add_done;
   logic issue, clear_sum, done_d;
   logic [31:0] issue_dat, result_d;

   assign accept    = clk_en && start && (state_q == IDLE);
   assign is_first  = (datab == FP_ONE);
   assign is_finish = (datab == FP_NEG_ONE);
   assign credit    = ({1'b0, inflight_q} + {1'b0, fifo_cnt}) < DEPTH_W;
   // A new array may only zero the sum once the previous one has fully retired.
   assign clear_ok  = (acc_q == ACC_IDLE) && fifo_empty;
   assign drained   = (inflight_q == '0) && fifo_empty && (acc_q == ACC_IDLE);
   assign go_idle   = accept && !is_finish && credit && (!is_first || clear_ok);
   assign go_wait   = (state_q == WAIT_CREDIT) && credit && (!pend_first_q || clear_ok);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_finish)    state_d = DRAIN;
               else if (!go_idle) state_d = WAIT_CREDIT;
            end
         end
         WAIT_CREDIT: if (go_wait) state_d = IDLE;
         DRAIN:       if (drained) state_d = RESPOND;
         RESPOND:     state_d = IDLE;
         default:     state_d = IDLE;
      endcase
   end

   always_comb begin
      issue     = go_idle || go_wait;
      issue_dat = go_wait ? pend_dat_q : dataa;
      clear_sum = (go_idle && is_first) || (go_wait && pend_first_q);
      done_d    = issue || ((state_q == DRAIN) && drained);
      result_d  = ((state_q == DRAIN) && drained) ? sum_q : FP_ZERO;
   end

   assign arrive = vld_sr_q[PIPE_LAT-1];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         done_q       <= 1'b0;
         result_q     <= FP_ZERO;
         pipe_valid_q <= 1'b0;
         pipe_x_q     <= '0;
         pend_dat_q   <= '0;
         pend_first_q <= 1'b0;
         vld_sr_q     <= '0;
         inflight_q   <= '0;
      end else begin
         done_q       <= done_d;
         result_q     <= result_d;
         pipe_valid_q <= issue;
         if (issue) pipe_x_q <= issue_dat;
         if (accept) begin
            pend_dat_q   <= dataa;
            pend_first_q <= is_first;
         end
         vld_sr_q   <= {vld_sr_q[PIPE_LAT-2:0], pipe_valid_q};
         inflight_q <= inflight_q + CW'(issue) - CW'(arrive);
      end
   end

   eval_res_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_res_fifo (
      .clk_i   (clock),
      .rst_ni  (reset),
      .push_i  (arrive),
      .wdata_i (pipe_q),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .count_o (fifo_cnt),
      .empty_o (fifo_empty)
   );

   assign pop      = (acc_q == ACC_IDLE) && !fifo_empty;
   assign add_done = (acc_q == ACC_WAIT) && (acc_cnt_q == '0);

   always_comb begin
      acc_d = acc_q;
      case (acc_q)
         ACC_IDLE: if (pop)      acc_d = ACC_WAIT;
         ACC_WAIT: if (add_done) acc_d = ACC_IDLE;
         default:  acc_d = ACC_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         acc_q     <= ACC_IDLE;
         acc_cnt_q <= '0;
         add_a_q   <= '0;
         add_b_q   <= '0;
         sum_q     <= FP_ZERO;
      end else begin
         acc_q <= acc_d;
         if (pop) begin
            add_a_q   <= sum_q;
            add_b_q   <= fifo_rdata;
            acc_cnt_q <= AW'(ADD_LAT);
         end else if ((acc_q == ACC_WAIT) && !add_done) begin
            acc_cnt_q <= acc_cnt_q - 1'b1;
         end
         if (clear_sum)     sum_q <= FP_ZERO;
         else if (add_done) sum_q <= add_q;
      end
   end

   assign done       = done_q;
   assign result     = result_q;
   assign pipe_valid = pipe_valid_q;
   assign pipe_x     = pipe_x_q;
   assign add_a      = add_a_q;
   assign add_b      = add_b_q;

endmodule

// File: tb/tb_eval_sequencer.sv
// Bench for eval_sequencer: delay-line datapath and adder models, instruction-level sum model.
module tb_eval_sequencer;

   localparam int PIPE_LAT   = 34;
   localparam int ADD_LAT    = 3;
   localparam int FIFO_DEPTH = 8;
   localparam logic [31:0] C_FIRST  = 32'h3F80_0000;
   localparam logic [31:0] C_FINISH = 32'hBF80_0000;
   localparam logic [31:0] C_ELEM   = 32'h0000_0000;

   logic        clock, reset, clk_en, start;
   logic [31:0] dataa, datab, result, pipe_x, pipe_q, add_a, add_b, add_q;
   logic        done, pipe_valid;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   bit mon_en = 0;
   bit mon_el;
   int model_sum = 0;
   logic [31:0] exp_pipe[$];
   logic [31:0] exp_done[$];
   bit          exp_elem[$];

   logic [31:0] ph [PIPE_LAT];
   logic [31:0] ha [ADD_LAT];
   logic [31:0] hb [ADD_LAT];

   eval_sequencer #(.PIPE_LAT(PIPE_LAT), .ADD_LAT(ADD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clock(clock), .reset(reset), .clk_en(clk_en), .start(start),
      .dataa(dataa), .datab(datab), .done(done), .result(result),
      .pipe_valid(pipe_valid), .pipe_x(pipe_x), .pipe_q(pipe_q),
      .add_a(add_a), .add_b(add_b), .add_q(add_q)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic real sp2r(input logic [31:0] b);
      logic [10:0] e;
      if (b[30:0] == 31'd0) return 0.0;
      e = 11'(b[30:23]) + 11'd896;
      return $bitstoreal({b[31], e, b[22:0], 29'd0});
   endfunction

   function automatic logic [31:0] r2sp(input real r);
      logic [63:0] d;
      logic [10:0] e;
      if (r == 0.0) return 32'h0;
      d = $realtobits(r);
      e = d[62:52] - 11'd896;
      return {d[63], e[7:0], d[51:29]};
   endfunction

   function automatic logic [31:0] int2sp(input int n);
      int e;
      logic [31:0] u, m;
      if (n <= 0) return 32'h0;
      u = n;
      e = 0;
      for (int i = 0; i < 31; i++) if (u[i]) e = i;
      m = u << (23 - e);
      return {1'b0, 8'(127 + e), m[22:0]};
   endfunction

   // Datapath and adder: pure delay lines that never reset, so stale values keep arriving.
   always @(posedge clock) begin
      cyc   <= cyc + 1;
      ph[0] <= pipe_x;
      for (int i = 1; i < PIPE_LAT; i++) ph[i] <= ph[i-1];
      ha[0] <= add_a;
      hb[0] <= add_b;
      for (int i = 1; i < ADD_LAT; i++) begin
         ha[i] <= ha[i-1];
         hb[i] <= hb[i-1];
      end
   end
   assign pipe_q = ph[PIPE_LAT-1];
   assign add_q  = r2sp(sp2r(ha[ADD_LAT-1]) + sp2r(hb[ADD_LAT-1]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clock) begin
      if (mon_en) begin
         if (pipe_valid) begin
            if (exp_pipe.size() == 0) check("pipe_valid_spurious", 32'(pipe_valid), 32'd0);
            else check("pipe_x", pipe_x, exp_pipe.pop_front());
         end
         if (done) begin
            if (exp_done.size() == 0) check("done_spurious", 32'(done), 32'd0);
            else begin
               mon_el = exp_elem.pop_front();
               check("result", result, exp_done.pop_front());
               if (mon_el) check("done_with_issue", 32'(pipe_valid), 32'd1);
            end
         end
      end
   end

   task automatic expect_instr(input logic [31:0] cmd, input int val);
      if (cmd == C_FINISH) begin
         exp_done.push_back(int2sp(model_sum));
         exp_elem.push_back(1'b0);
      end else begin
         if (cmd == C_FIRST) model_sum = val;
         else                model_sum += val;
         exp_pipe.push_back(int2sp(val));
         exp_done.push_back(32'h0);
         exp_elem.push_back(1'b1);
      end
   endtask

   task automatic do_instr(input logic [31:0] cmd, input int val, input int stall,
                           output int lat, output logic [31:0] res, output logic [31:0] px);
      @(negedge clock);
      start  = 1'b1;
      dataa  = int2sp(val);
      datab  = cmd;
      clk_en = 1'b0;
      repeat (stall) @(negedge clock);
      expect_instr(cmd, val);
      clk_en = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start  = 1'b0;
      clk_en = 1'($urandom_range(0, 1));
      lat = 1;
      while (!done && lat < 1000) begin
         @(negedge clock);
         lat++;
      end
      res = result;
      px  = pipe_x;
      if (!done) begin
         n_chk++;
         n_fail++;
         $display("FAIL done_timeout: no done after %0d cycles, required a done pulse", lat);
      end
   endtask

   task automatic apply_reset(input int n);
      @(negedge clock);
      mon_en = 1'b0;
      reset  = 1'b0;
      start  = 1'b0;
      clk_en = 1'b0;
      #1;
      check("rst_done", 32'(done), 32'd0);
      check("rst_pipe_valid", 32'(pipe_valid), 32'd0);
      check("rst_result", result, 32'h0);
      check("rst_pipe_x", pipe_x, 32'h0);
      check("rst_add_a", add_a, 32'h0);
      check("rst_add_b", add_b, 32'h0);
      repeat (n) @(negedge clock);
      exp_pipe.delete();
      exp_done.delete();
      exp_elem.delete();
      model_sum = 0;
      reset  = 1'b1;
      mon_en = 1'b1;
   endtask

   initial begin
      int lat, c0, n, v;
      int lats[10];
      logic [31:0] res, px, w;
      reset = 1'b0; clk_en = 1'b0; start = 1'b0; dataa = '0; datab = '0;

      apply_reset(3);
      repeat (3) begin
         @(negedge clock);
         check("idle_done", 32'(done), 32'd0);
         check("idle_pipe_valid", 32'(pipe_valid), 32'd0);
         check("idle_result", result, 32'h0);
      end

      do_instr(C_FIRST, 2, 0, lat, res, px);
      check("first_latency", 32'(lat), 32'd1);
      check("first_pipe_x", px, 32'h4000_0000);
      check("first_result", res, 32'h0);
      do_instr(C_FINISH, 0, 0, lat, res, px);
      check("single_sum", res, 32'h4000_0000);

      do_instr(C_FIRST, 1, 0, lat, res, px);
      c0 = cyc;
      do_instr(C_ELEM, 2, 0, lat, res, px);
      do_instr(32'h1234_5678, 3, 0, lat, res, px);
      do_instr(C_FINISH, 0, 0, lat, res, px);
      check("sum_1_2_3", res, 32'h40C0_0000);
      check("sum_1_2_3_min_latency", 32'((cyc - c0) >= PIPE_LAT + 3 * ADD_LAT), 32'd1);

      do_instr(C_FIRST, 1, 0, lats[0], res, px);
      for (int i = 1; i < 10; i++) do_instr(C_ELEM, 1, 0, lats[i], res, px);
      for (int i = 0; i < 8; i++) check("credit_latency", 32'(lats[i]), 32'd1);
      check("credit_9th_stalled", 32'(lats[8] > 1), 32'd1);
      do_instr(C_FINISH, 0, 0, lat, res, px);
      check("sum_ten_ones", res, 32'h4120_0000);

      apply_reset(2);
      do_instr(C_FINISH, 0, 0, lat, res, px);
      check("empty_finish_latency", 32'(lat), 32'd2);
      check("empty_finish_result", res, 32'h0);

      do_instr(C_FIRST, 1, 0, lat, res, px);
      for (int i = 2; i <= 4; i++) do_instr(C_ELEM, i, 0, lat, res, px);
      @(negedge clock);
      start = 1'b1; datab = C_FINISH; clk_en = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      repeat (10) @(negedge clock);
      apply_reset(2);
      do_instr(C_FIRST, 5, 0, lat, res, px);
      do_instr(C_FINISH, 0, 0, lat, res, px);
      check("after_reset_sum", res, 32'h40A0_0000);

      for (int a = 0; a < 6; a++) begin
         n = $urandom_range(1, 12);
         for (int i = 0; i < n; i++) begin
            v = $urandom_range(1, 8);
            w = $urandom;
            if (w == C_FIRST || w == C_FINISH) w = C_ELEM;
            do_instr((i == 0) ? C_FIRST : w, v, $urandom_range(0, 3), lat, res, px);
         end
         do_instr(C_FINISH, 0, $urandom_range(0, 3), lat, res, px);
      end

      repeat (5) @(negedge clock);
      check("queues_drained", 32'(exp_pipe.size() + exp_done.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/eval_sequencer.md
EVAL_SEQUENCER -- requirements
Module: eval_sequencer

Interface
REQ-001 Parameter PIPE_LAT, default 34: fixed latency in cycles from pipe_valid to matching pipe_q of the evaluate datapath.
REQ-002 Parameter ADD_LAT, default 3: latency in cycles of the external FP adder from add_a/add_b to add_q.
REQ-003 Parameter FIFO_DEPTH, default 8: result buffer depth, power of two, at least 2.
REQ-004 Ports, in this order:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low.
- clk_en  in  1  custom-instruction enable.
- start  in  1  instruction request.
- dataa  in  32  element x[i], IEEE-754 single.
- datab  in  32  command word.
- done  out  1  one-cycle completion pulse.
- result  out  32  instruction result.
- pipe_valid  out  1  element issue strobe.
- pipe_x  out  32  issued element.
- pipe_q  in  32  datapath output.
- add_a  out  32  adder operand.
- add_b  out  32  adder operand.
- add_q  in  32  adder output.

Function
REQ-005 Command decode by datab:
- 0x3F800000 = FIRST: clear the sum, then issue dataa.
- 0xBF800000 = FINISH: issue nothing, return the sum.
- Any other value = ELEM: issue dataa.
REQ-006 start is sampled only when clk_en=1 and the FSM is in IDLE; start in any other state is ignored.
REQ-007 Handshake FSM states are IDLE, WAIT_CREDIT, DRAIN and RESPOND.
REQ-008 outstanding = in-flight count + FIFO occupancy; credit exists when outstanding < FIFO_DEPTH.
REQ-009 FIRST/ELEM with credit, in the cycle after the start edge:
- pipe_valid=1 and pipe_x=dataa for exactly one cycle.
- done=1 and result=0x00000000.
- The FSM stays in IDLE.
REQ-010 FIRST/ELEM without credit: latch dataa and enter WAIT_CREDIT; issue and pulse done in the first cycle credit exists, then return to IDLE.
REQ-011 FINISH: enter DRAIN and stay there until in-flight=0, FIFO empty and adder idle; next cycle go to RESPOND, drive done=1 and result=sum for one cycle, then return to IDLE.
REQ-012 FINISH with nothing outstanding: done arrives 2 cycles after the start edge.
REQ-013 In-flight tracking is a PIPE_LAT-deep valid shift register that always advances, independent of clk_en.
- Its output pushes pipe_q into the FIFO.
- The in-flight count increments on issue and decrements on arrival; simultaneous issue and arrival leave it unchanged.
REQ-014 Accumulator FSM states are ACC_IDLE and ACC_WAIT.
- In ACC_IDLE with the FIFO non-empty: pop, drive add_a=sum and add_b=head, start a counter of ADD_LAT, enter ACC_WAIT.
- When the counter expires: sum<=add_q, return to ACC_IDLE.
- Exactly one addition is in flight at a time.
REQ-015 A FIFO push and pop in the same cycle leaves occupancy unchanged; push when full and pop when empty cannot occur, by the credit rule.
REQ-016 FIRST clears the sum only when the accumulator is in ACC_IDLE with the FIFO empty; otherwise it is held in WAIT_CREDIT until that condition holds.
REQ-017 clk_en=0 blocks new acceptance only; draining and accumulation continue.

Reset
REQ-018 On reset=0, asynchronously:
- done=0, result=0, pipe_valid=0, pipe_x=0, add_a=0, add_b=0.
- sum=0x00000000.
- Valid shift register cleared, FIFO emptied, both FSMs idle.
REQ-019 Datapath outputs arriving after reset mid-operation are discarded, because their valid bits were cleared.

Structure
REQ-020 Shared package eval_pkg holds FP_ONE, FP_NEG_ONE, FP_ZERO and the FSM state enums.
REQ-021 The result buffer is sub-module eval_res_fifo (synchronous FIFO, width 32, depth FIFO_DEPTH); all other logic is inline.

Verification
The bench models pipe_q = pipe_x delayed PIPE_LAT cycles, and add_q = add_a+add_b delayed ADD_LAT cycles.
REQ-022 Hold reset=0 for 3 cycles, then release -> done=0, pipe_valid=0, result=0 throughout.
REQ-023 start with dataa=0x40000000, datab=0x3F800000 -> next cycle pipe_valid=1, pipe_x=0x40000000, done=1, result=0.
REQ-024 FIRST 1.0, ELEM 2.0, ELEM 3.0, then FINISH -> a single done pulse with result=0x40C00000 (6.0), no earlier than PIPE_LAT+3*ADD_LAT cycles after the first issue.
REQ-025 10 back-to-back elements of 1.0 with FIFO_DEPTH=8, then FINISH -> the 9th done is delayed until credit exists, no element is lost, and the final result=0x41200000 (10.0).
REQ-026 FINISH with no elements after reset -> done 2 cycles after the start edge, result=0x00000000.
REQ-027 Assert reset during DRAIN of a 4-element array, then run a new array of FIRST 5.0 and FINISH -> result=0x40A00000; stale pipe_q values are not accumulated.
